// File: rtl/dcache_sram.sv
// Single-port synchronous RAM model for the L1 data cache arrays: chunked write enables,
// optional per-word user sideband, 1-cycle read latency plus an optional output stage.
module dcache_sram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned USER_EN    = 0,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned OUT_REGS   = 0,
  parameter int unsigned INIT_ZERO  = 0,
  localparam int unsigned AW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned BEW = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [USER_WIDTH-1:0] wuser_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BEW-1:0]        be_i,
  output logic [USER_WIDTH-1:0] ruser_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
  logic [DATA_WIDTH-1:0] w_wmask;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [USER_WIDTH-1:0] r_ruser;
  logic [USER_WIDTH-1:0] w_mem_ruser;
  logic                  w_in_range;
  logic                  w_wr;
  logic                  w_rd;

  // Expand chunk enables to a per-bit mask; the last chunk is naturally clipped at DATA_WIDTH.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_wmask
    assign w_wmask[i] = be_i[i / BYTE_WIDTH];
  end

  if (NUM_WORDS == (2 ** AW)) begin : g_full_range
    assign w_in_range = 1'b1;
  end else begin : g_part_range
    assign w_in_range = ({{(32 - AW){1'b0}}, addr_i} < NUM_WORDS);
  end

  assign w_wr = req_i & we_i & w_in_range;
  assign w_rd = req_i & ~we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if (INIT_ZERO != 0) begin
        for (int unsigned n = 0; n < NUM_WORDS; n++) begin
          r_mem[AW'(n)] <= '0;
        end
      end
    end else if (w_wr) begin
      r_mem[addr_i] <= (r_mem[addr_i] & ~w_wmask) | (wdata_i & w_wmask);
    end
  end

  if (USER_EN != 0) begin : g_user
    logic [USER_WIDTH-1:0] r_umem [NUM_WORDS];
    logic [USER_WIDTH-1:0] w_umask;

    // User bits share the data chunk mapping; bits beyond the last chunk are never written.
    for (genvar j = 0; j < USER_WIDTH; j++) begin : g_umask
      if ((j / BYTE_WIDTH) < BEW) begin : g_on
        assign w_umask[j] = be_i[j / BYTE_WIDTH];
      end else begin : g_off
        assign w_umask[j] = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        if (INIT_ZERO != 0) begin
          for (int unsigned n = 0; n < NUM_WORDS; n++) begin
            r_umem[AW'(n)] <= '0;
          end
        end
      end else if (w_wr) begin
        r_umem[addr_i] <= (r_umem[addr_i] & ~w_umask) | (wuser_i & w_umask);
      end
    end

    assign w_mem_ruser = r_umem[addr_i];
  end else begin : g_no_user
    logic w_unused_user;
    assign w_unused_user = ^wuser_i;
    assign w_mem_ruser   = '0;
  end

  // Read register only moves on a read; writes and idle cycles hold the last result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata <= '0;
      r_ruser <= '0;
    end else if (w_rd) begin
      r_rdata <= w_in_range ? r_mem[addr_i] : '0;
      r_ruser <= w_in_range ? w_mem_ruser : '0;
    end
  end

  if (OUT_REGS != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_rdata_q;
    logic [USER_WIDTH-1:0] r_ruser_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_rdata_q <= '0;
        r_ruser_q <= '0;
      end else begin
        r_rdata_q <= r_rdata;
        r_ruser_q <= r_ruser;
      end
    end

    assign rdata_o = r_rdata_q;
    assign ruser_o = r_ruser_q;
  end else begin : g_no_out_reg
    assign rdata_o = r_rdata;
    assign ruser_o = r_ruser;
  end

endmodule

// File: tb/tb_dcache_sram.sv
// Scoreboarded bench for dcache_sram: three instances cover the 64-bit/user/odd-depth,
// 20-bit/output-register and 4-bit/bit-granular configurations.
module tb_dcache_sram;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Instance A: 64-bit, 4-bit user, depth 12, cleared on reset, latency 1
  logic        req_a = 1'b0, we_a = 1'b0;
  logic [3:0]  addr_a = '0, wuser_a = '0, ruser_a;
  logic [63:0] wdata_a = '0, rdata_a;
  logic [7:0]  be_a = '0;
  // Instance B: 20-bit, depth 16, retained over reset, latency 2
  logic        req_b = 1'b0, we_b = 1'b0;
  logic [3:0]  addr_b = '0;
  logic [0:0]  wuser_b = '0, ruser_b;
  logic [19:0] wdata_b = '0, rdata_b;
  logic [2:0]  be_b = '0;
  // Instance C: 4-bit, bit-granular, depth 4, cleared on reset
  logic        req_c = 1'b0, we_c = 1'b0;
  logic [1:0]  addr_c = '0;
  logic [0:0]  wuser_c = '0, ruser_c;
  logic [3:0]  wdata_c = '0, rdata_c, be_c = '0;

  dcache_sram #(.DATA_WIDTH(64), .USER_WIDTH(4), .USER_EN(1), .NUM_WORDS(12),
                .BYTE_WIDTH(8), .OUT_REGS(0), .INIT_ZERO(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wuser_i(wuser_a), .wdata_i(wdata_a), .be_i(be_a), .ruser_o(ruser_a), .rdata_o(rdata_a));

  dcache_sram #(.DATA_WIDTH(20), .USER_WIDTH(1), .USER_EN(0), .NUM_WORDS(16),
                .BYTE_WIDTH(8), .OUT_REGS(1), .INIT_ZERO(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wuser_i(wuser_b), .wdata_i(wdata_b), .be_i(be_b), .ruser_o(ruser_b), .rdata_o(rdata_b));

  dcache_sram #(.DATA_WIDTH(4), .USER_WIDTH(1), .USER_EN(0), .NUM_WORDS(4),
                .BYTE_WIDTH(1), .OUT_REGS(0), .INIT_ZERO(1)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .we_i(we_c), .addr_i(addr_c),
    .wuser_i(wuser_c), .wdata_i(wdata_c), .be_i(be_c), .ruser_o(ruser_c), .rdata_o(rdata_c));

  typedef struct { logic [63:0] d; logic [3:0] u; } exp_a_t;
  typedef struct { int due; logic [19:0] d; } exp_b_t;

  exp_a_t     qa [$];
  exp_b_t     qb [$];
  logic [3:0] qc [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [63:0] wd, input logic [7:0] be,
                      input logic [3:0] wu);
    req_a = 1'b1; we_a = 1'b1; addr_a = a; wdata_a = wd; be_a = be; wuser_a = wu;
    step();
    req_a = 1'b0; we_a = 1'b0;
  endtask

  task automatic rd_a(input logic [3:0] a, input logic [63:0] ed, input logic [3:0] eu);
    req_a = 1'b1; we_a = 1'b0; addr_a = a;
    qa.push_back('{d: ed, u: eu});
    step();
    req_a = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [19:0] wd, input logic [2:0] be);
    req_b = 1'b1; we_b = 1'b1; addr_b = a; wdata_b = wd; be_b = be;
    step();
    req_b = 1'b0; we_b = 1'b0;
  endtask

  task automatic rd_b(input logic [3:0] a, input logic [19:0] ed);
    req_b = 1'b1; we_b = 1'b0; addr_b = a;
    qb.push_back('{due: cycle + 2, d: ed});
    step();
    req_b = 1'b0;
  endtask

  task automatic wr_c(input logic [1:0] a, input logic [3:0] wd, input logic [3:0] be);
    req_c = 1'b1; we_c = 1'b1; addr_c = a; wdata_c = wd; be_c = be;
    step();
    req_c = 1'b0; we_c = 1'b0;
  endtask

  task automatic rd_c(input logic [1:0] a, input logic [3:0] ed);
    req_c = 1'b1; we_c = 1'b0; addr_c = a;
    qc.push_back(ed);
    step();
    req_c = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (rdata_a !== 64'h0 || ruser_a !== 4'h0) begin
      errors++;
      $display("FAIL reset_a: rdata=%h ruser=%h expected 0/0", rdata_a, ruser_a);
    end
    checks++;
    if (rdata_b !== 20'h0 || ruser_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: rdata=%h ruser=%h expected 0/0", rdata_b, ruser_b);
    end
    checks++;
    if (rdata_c !== 4'h0 || ruser_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_c: rdata=%h ruser=%h expected 0/0", rdata_c, ruser_c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    exp_a_t e;
    wr_a(4'd5, 64'hDEADBEEF_01234567, 8'hFF, 4'h9);
    checks++;
    if (rdata_a !== 64'h0) begin
      errors++;
      $display("FAIL write_no_update: rdata=%h expected %h", rdata_a, 64'h0);
    end
    rd_a(4'd5, 64'hDEADBEEF_01234567, 4'h9);
    e = qa.pop_front();
    checks++;
    if (rdata_a !== e.d || ruser_a !== e.u) begin
      errors++;
      $display("FAIL basic_read: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, e.d, e.u);
    end
  endtask

  task automatic test_partial_be();
    exp_a_t e;
    wr_a(4'd5, {64{1'b1}}, 8'h0F, 4'hF);
    rd_a(4'd5, 64'hDEADBEEF_FFFFFFFF, 4'hF);
    e = qa.pop_front();
    checks++;
    if (rdata_a !== e.d || ruser_a !== e.u) begin
      errors++;
      $display("FAIL partial_be_lo: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, e.d, e.u);
    end
    wr_a(4'd5, 64'h0, 8'h00, 4'h0);
    rd_a(4'd5, 64'hDEADBEEF_FFFFFFFF, 4'hF);
    e = qa.pop_front();
    checks++;
    if (rdata_a !== e.d || ruser_a !== e.u) begin
      errors++;
      $display("FAIL be_zero: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, e.d, e.u);
    end
    // upper chunks only: user bits live in chunk 0, so they must stay put
    wr_a(4'd5, 64'h0, 8'hF0, 4'h0);
    rd_a(4'd5, 64'h00000000_FFFFFFFF, 4'hF);
    e = qa.pop_front();
    checks++;
    if (rdata_a !== e.d || ruser_a !== e.u) begin
      errors++;
      $display("FAIL partial_be_hi: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, e.d, e.u);
    end
  endtask

  task automatic test_hold();
    exp_a_t e;
    wr_a(4'd3, 64'h11, 8'hFF, 4'h1);
    rd_a(4'd3, 64'h11, 4'h1);
    e = qa.pop_front();
    checks++;
    if (rdata_a !== e.d || ruser_a !== e.u) begin
      errors++;
      $display("FAIL hold_first_read: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, e.d, e.u);
    end
    wr_a(4'd3, 64'h22, 8'hFF, 4'h2);
    step();
    step();
    checks++;
    if (rdata_a !== 64'h11 || ruser_a !== 4'h1) begin
      errors++;
      $display("FAIL hold_after_write: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, 64'h11, 4'h1);
    end
    rd_a(4'd3, 64'h22, 4'h2);
    e = qa.pop_front();
    checks++;
    if (rdata_a !== e.d || ruser_a !== e.u) begin
      errors++;
      $display("FAIL hold_reread: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, e.d, e.u);
    end
  endtask

  task automatic test_out_of_range();
    exp_a_t e;
    wr_a(4'd11, 64'h01234567_89ABCDEF, 8'hFF, 4'hC);
    wr_a(4'd13, 64'hBAD0BAD0_BAD0BAD0, 8'hFF, 4'h3);
    rd_a(4'd13, 64'h0, 4'h0);
    e = qa.pop_front();
    checks++;
    if (rdata_a !== e.d || ruser_a !== e.u) begin
      errors++;
      $display("FAIL oor_read: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, e.d, e.u);
    end
    rd_a(4'd11, 64'h01234567_89ABCDEF, 4'hC);
    e = qa.pop_front();
    checks++;
    if (rdata_a !== e.d || ruser_a !== e.u) begin
      errors++;
      $display("FAIL last_word: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, e.d, e.u);
    end
    // addr 13 aliases addr 5 if the upper address bit were dropped
    rd_a(4'd5, 64'h00000000_FFFFFFFF, 4'hF);
    e = qa.pop_front();
    checks++;
    if (rdata_a !== e.d || ruser_a !== e.u) begin
      errors++;
      $display("FAIL oor_alias: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, e.d, e.u);
    end
  endtask

  task automatic test_bit_granular();
    logic [3:0] e;
    rd_c(2'd2, 4'b0000);
    e = qc.pop_front();
    checks++;
    if (rdata_c !== e) begin
      errors++;
      $display("FAIL bitgran_init: rdata=%b expected %b", rdata_c, e);
    end
    wr_c(2'd2, 4'b1111, 4'b0101);
    rd_c(2'd2, 4'b0101);
    e = qc.pop_front();
    checks++;
    if (rdata_c !== e) begin
      errors++;
      $display("FAIL bitgran_set: rdata=%b expected %b", rdata_c, e);
    end
    wr_c(2'd2, 4'b0000, 4'b0001);
    rd_c(2'd2, 4'b0100);
    e = qc.pop_front();
    checks++;
    if (rdata_c !== e) begin
      errors++;
      $display("FAIL bitgran_clr: rdata=%b expected %b", rdata_c, e);
    end
  endtask

  task automatic test_odd_width();
    exp_b_t e;
    wr_b(4'd4, 20'h00000, 3'b111);
    wr_b(4'd4, 20'hABCDE, 3'b100);
    rd_b(4'd4, 20'hA0000);
    step();
    e = qb.pop_front();
    checks++;
    if (rdata_b !== e.d) begin
      errors++;
      $display("FAIL odd_width_top: rdata=%h expected %h", rdata_b, e.d);
    end
    wr_b(4'd4, 20'h12345, 3'b011);
    rd_b(4'd4, 20'hA2345);
    step();
    e = qb.pop_front();
    checks++;
    if (rdata_b !== e.d) begin
      errors++;
      $display("FAIL odd_width_low: rdata=%h expected %h", rdata_b, e.d);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] pv [3];
    logic [19:0] cur;
    pv[0] = 20'h11111; pv[1] = 20'h22222; pv[2] = 20'h33333;
    for (int k = 0; k < 3; k++) wr_b(4'(k), pv[k], 3'b111);
    cur = 20'hA2345;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        req_b = 1'b1; we_b = 1'b0; addr_b = 4'(i);
        qb.push_back('{due: cycle + 2, d: pv[i]});
      end else begin
        req_b = 1'b0;
      end
      @(negedge clk);
      if (qb.size() > 0 && qb[0].due == cycle) cur = qb.pop_front().d;
      checks++;
      if (rdata_b !== cur) begin
        errors++;
        $display("FAIL pipeline_step%0d: rdata=%h expected %h", i, rdata_b, cur);
      end
      step();
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL pipeline_drain: pending=%0d expected 0", qb.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_a_t ea;
    exp_b_t eb;
    logic [3:0] ec;
    wr_a(4'd7, 64'h5A, 8'hFF, 4'h5);
    rd_a(4'd7, 64'h5A, 4'h5);
    ea = qa.pop_front();
    checks++;
    if (rdata_a !== ea.d || ruser_a !== ea.u) begin
      errors++;
      $display("FAIL pre_reset_a: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, ea.d, ea.u);
    end
    wr_b(4'd7, 20'h0005A, 3'b111);
    rd_b(4'd7, 20'h0005A);
    step();
    eb = qb.pop_front();
    checks++;
    if (rdata_b !== eb.d) begin
      errors++;
      $display("FAIL pre_reset_b: rdata=%h expected %h", rdata_b, eb.d);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdata_a !== 64'h0 || ruser_a !== 4'h0 || rdata_b !== 20'h0 || rdata_c !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: a=%h/%h b=%h c=%h expected all 0", rdata_a, ruser_a, rdata_b, rdata_c);
    end
    // requests issued while reset is held must be discarded
    req_b = 1'b1; we_b = 1'b1; addr_b = 4'd7; wdata_b = 20'hFFFFF; be_b = 3'b111;
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd11;
    step();
    req_a = 1'b0; req_b = 1'b0; we_b = 1'b0;
    checks++;
    if (rdata_a !== 64'h0 || rdata_b !== 20'h0) begin
      errors++;
      $display("FAIL req_in_reset: a=%h b=%h expected 0/0", rdata_a, rdata_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rd_a(4'd7, 64'h0, 4'h0);
    ea = qa.pop_front();
    checks++;
    if (rdata_a !== ea.d || ruser_a !== ea.u) begin
      errors++;
      $display("FAIL init_zero_a: rdata=%h ruser=%h expected %h/%h", rdata_a, ruser_a, ea.d, ea.u);
    end
    rd_b(4'd7, 20'h0005A);
    step();
    eb = qb.pop_front();
    checks++;
    if (rdata_b !== eb.d) begin
      errors++;
      $display("FAIL retain_b: rdata=%h expected %h", rdata_b, eb.d);
    end
    rd_c(2'd2, 4'b0000);
    ec = qc.pop_front();
    checks++;
    if (rdata_c !== ec) begin
      errors++;
      $display("FAIL init_zero_c: rdata=%b expected %b", rdata_c, ec);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_be();
    test_hold();
    test_out_of_range();
    test_bit_granular();
    test_odd_width();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
